// File: rtl/rs_dec_ctrl_pkg.sv
//==============================================================================
// Module   : rs_pkg
// Purpose  : Shared types and constants for the RS(255,251) decoder control
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package rs_pkg;

  localparam int RS_N = 255;
  localparam int RS_K = 251;
  localparam int RS_T = 2;

  // Error-locator degree reported by the key-equation solver when the
  // codeword cannot be corrected.
  localparam logic [1:0] ERR_UNCORR = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYND   = 3'd1,
    KES    = 3'd2,
    CHIEN  = 3'd3,
    CORR   = 3'd4,
    REPORT = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rs_dec_wdog.sv
//==============================================================================
// Module   : rs_dec_wdog
// Purpose  : Per-stage watchdog. Counts cycles while enabled, clears on
//            request, flags expiry on the last allowed cycle of a stage.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rs_dec_wdog #(
  parameter int WDOG_CYC = 512,
  parameter int WDOG_W   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  // Cycle counter: clear wins over count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  assign expire = en && (cnt == WDOG_W'(WDOG_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/rs_dec_ctrl.sv
//==============================================================================
// Module   : rs_dec_ctrl
// Purpose  : Sequences one RS(255,251) codeword through syndrome, key-equation
//            solver, Chien search and correction, then reports the result.
//            Owns the ping-pong buffer select, a one-deep pending request and
//            a per-stage watchdog.
// Options  : RS_DEC_STATS_EN - adds stat_clr input and saturating result
//            counters stat_blk / stat_corr / stat_fail.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rs_dec_ctrl #(
  parameter int WDOG_CYC = 512,
  parameter int WDOG_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_req,
  output logic        blk_ovf,
  output logic        buf_wr_sel,
  output logic        buf_rd_sel,
  output logic        synd_start,
  input  logic        synd_done,
  input  logic        synd_zero,
  output logic        kes_start,
  input  logic        kes_done,
  input  logic [1:0]  kes_err_num,
  output logic        chien_start,
  output logic [1:0]  chien_err_num,
  input  logic        chien_done,
  input  logic [1:0]  chien_found,
  output logic        corr_start,
  input  logic        corr_done,
  output logic        busy,
  output logic        res_valid,
  output logic        res_ok,
  output logic [1:0]  res_nerr,
`ifdef RS_DEC_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_blk,
  output logic [15:0] stat_corr,
  output logic [15:0] stat_fail,
`endif
  output logic        res_tmo
);

  import rs_pkg::*;

  state_t state;
  logic   pending;
  logic   done_acc;
  logic   in_stage;
  logic   wd_clr;
  logic   wd_expire;

  // A stage's done pulse counts only in its own state and never on the
  // cycle its start pulse is still high.
  always_comb begin
    done_acc = 1'b0;
    case (state)
      SYND:    done_acc = synd_done  & ~synd_start;
      KES:     done_acc = kes_done   & ~kes_start;
      CHIEN:   done_acc = chien_done & ~chien_start;
      CORR:    done_acc = corr_done  & ~corr_start;
      default: done_acc = 1'b0;
    endcase
  end

  assign in_stage = (state == SYND) || (state == KES) ||
                    (state == CHIEN) || (state == CORR);
  assign busy     = (state != IDLE);

  // Every exit from a stage clears the counter, so each new stage
  // begins counting from zero on its first cycle.
  assign wd_clr = ~in_stage | done_acc | wd_expire;

  rs_dec_wdog #(
    .WDOG_CYC (WDOG_CYC),
    .WDOG_W   (WDOG_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (in_stage),
    .expire (wd_expire)
  );

  // Stage sequencer: start pulses, pending capture, buffer select, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      blk_ovf       <= 1'b0;
      buf_wr_sel    <= 1'b0;
      buf_rd_sel    <= 1'b0;
      synd_start    <= 1'b0;
      kes_start     <= 1'b0;
      chien_start   <= 1'b0;
      corr_start    <= 1'b0;
      chien_err_num <= 2'd0;
      res_valid     <= 1'b0;
      res_ok        <= 1'b0;
      res_nerr      <= 2'd0;
      res_tmo       <= 1'b0;
    end else begin
      synd_start  <= 1'b0;
      kes_start   <= 1'b0;
      chien_start <= 1'b0;
      corr_start  <= 1'b0;
      res_valid   <= 1'b0;
      res_ok      <= 1'b0;
      res_nerr    <= 2'd0;
      res_tmo     <= 1'b0;

      // Requests while busy (REPORT included) wait one deep; a second is lost.
      if (state != IDLE && blk_req) begin
        if (pending) begin
          blk_ovf <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pending || blk_req) begin
            state      <= SYND;
            synd_start <= 1'b1;
            buf_rd_sel <= buf_wr_sel;
            buf_wr_sel <= ~buf_wr_sel;
            // Consuming a pending block while a fresh request arrives
            // leaves the fresh one pending.
            pending    <= pending & blk_req;
          end
        end
        SYND: begin
          if (done_acc) begin
            if (synd_zero) begin
              state     <= REPORT;
              res_valid <= 1'b1;
              res_ok    <= 1'b1;
            end else begin
              state     <= KES;
              kes_start <= 1'b1;
            end
          end
        end
        KES: begin
          if (done_acc) begin
            if (kes_err_num == 2'd0 || kes_err_num == ERR_UNCORR) begin
              state     <= REPORT;
              res_valid <= 1'b1;
            end else begin
              state         <= CHIEN;
              chien_start   <= 1'b1;
              chien_err_num <= kes_err_num;
            end
          end
        end
        CHIEN: begin
          if (done_acc) begin
            if (chien_found == chien_err_num) begin
              state      <= CORR;
              corr_start <= 1'b1;
            end else begin
              state     <= REPORT;
              res_valid <= 1'b1;
            end
          end
        end
        CORR: begin
          if (done_acc) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_ok    <= 1'b1;
            res_nerr  <= chien_err_num;
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Watchdog abort; a done pulse on the expiry cycle takes precedence.
      if (in_stage && !done_acc && wd_expire) begin
        state     <= REPORT;
        res_valid <= 1'b1;
        res_tmo   <= 1'b1;
      end
    end
  end

`ifdef RS_DEC_STATS_EN
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Result statistics: saturating counters, clear beats a same-cycle count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_blk  <= 16'd0;
      stat_corr <= 16'd0;
      stat_fail <= 16'd0;
    end else if (stat_clr) begin
      stat_blk  <= 16'd0;
      stat_corr <= 16'd0;
      stat_fail <= 16'd0;
    end else if (res_valid) begin
      if (stat_blk != STAT_MAX) begin
        stat_blk <= stat_blk + 16'd1;
      end
      if (res_ok && res_nerr != 2'd0 && stat_corr != STAT_MAX) begin
        stat_corr <= stat_corr + 16'd1;
      end
      if (!res_ok && stat_fail != STAT_MAX) begin
        stat_fail <= stat_fail + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rs_dec_ctrl.sv
//==============================================================================
// Module   : tb_rs_dec_ctrl
// Purpose  : Self-checking bench for rs_dec_ctrl. A block-level timeline
//            model plans every codeword (stage latencies, outcomes, request
//            arrival, pending/overflow) up front, producing per-cycle stimulus
//            and expected outputs; a directed tail pins reset and a clean
//            block with literal values.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rs_dec_ctrl;

  localparam int N       = 12000;
  localparam int GEN_END = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blk_req = 1'b0;
  logic       synd_done = 1'b0, synd_zero = 1'b0;
  logic       kes_done = 1'b0, chien_done = 1'b0, corr_done = 1'b0;
  logic [1:0] kes_err_num = 2'd0, chien_found = 2'd0;
  logic       blk_ovf, buf_wr_sel, buf_rd_sel, synd_start, kes_start;
  logic       chien_start, corr_start, busy, res_valid, res_ok, res_tmo;
  logic [1:0] chien_err_num, res_nerr;

  rs_dec_ctrl #(.WDOG_CYC(512), .WDOG_W(10)) dut (
    .clk(clk), .rst(rst), .blk_req(blk_req), .blk_ovf(blk_ovf),
    .buf_wr_sel(buf_wr_sel), .buf_rd_sel(buf_rd_sel),
    .synd_start(synd_start), .synd_done(synd_done), .synd_zero(synd_zero),
    .kes_start(kes_start), .kes_done(kes_done), .kes_err_num(kes_err_num),
    .chien_start(chien_start), .chien_err_num(chien_err_num),
    .chien_done(chien_done), .chien_found(chien_found),
    .corr_start(corr_start), .corr_done(corr_done), .busy(busy),
    .res_valid(res_valid), .res_ok(res_ok), .res_nerr(res_nerr),
    .res_tmo(res_tmo)
  );

  always #5 clk = ~clk;

  // Planned stimulus (index = cycle). Stage id: 0 synd, 1 kes, 2 chien, 3 corr.
  bit         d_req    [N];
  bit         d_done   [4][N];
  bit         win      [4][N];
  bit         d_szero  [N];
  logic [1:0] d_kerr   [N];
  logic [1:0] d_cfound [N];

  // Expected outputs per cycle
  bit         e_ss [N], e_ks [N], e_cs [N], e_xs [N];
  bit         e_rv [N], e_ok [N], e_tmo [N], e_busy [N];
  bit         e_rd [N], e_wr [N], e_ovf [N];
  logic [1:0] e_nerr [N], e_cerr [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;
  bit run      = 1'b0;

  int n_blocks    = 0;
  int long_budget = 6;
  int s_cur       = -100;
  int r_cur       = -100;
  int waiting     = -1;
  bit force_tmo   = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Plan one stage starting at t0; returns its last cycle (next stage at +1).
  function automatic int run_stage(input int id, input int t0, output bit tmo);
    int d;
    tmo = 1'b0;
    if (force_tmo) begin
      force_tmo = 1'b0;
      tmo = 1'b1;
      d = 511;
    end else if (long_budget > 0 && $urandom_range(0, 19) == 0) begin
      long_budget--;
      tmo = ($urandom_range(0, 1) == 1);
      d = 511;   // 511 with done = done on the expiry cycle
    end else begin
      d = $urandom_range(1, 6);
    end
    for (int c = t0; c <= t0 + d && c < N; c++) win[id][c] = 1'b1;
    if (!tmo && t0 + d < N) d_done[id][t0 + d] = 1'b1;
    if ($urandom_range(0, 3) == 0 && t0 < N) d_done[id][t0] = 1'b1;
    return t0 + d;
  endfunction

  // Plan a whole block whose synd_start is on cycle s.
  function automatic void sched_block(input int s);
    int l, rep;
    bit tmo, ok;
    logic [1:0] e, f, nerr;
    ok = 1'b0;
    nerr = 2'd0;
    e_ss[s] = 1'b1;
    for (int c = s; c < N; c++) begin
      e_rd[c] = n_blocks[0];
      e_wr[c] = ~n_blocks[0];
    end
    l = run_stage(0, s, tmo);
    rep = l + 1;
    if (!tmo) begin
      d_szero[l] = ($urandom_range(0, 3) == 0);
      if (d_szero[l]) begin
        ok = 1'b1;
      end else begin
        e_ks[l + 1] = 1'b1;
        l = run_stage(1, l + 1, tmo);
        rep = l + 1;
        if (!tmo) begin
          e = 2'($urandom_range(0, 3));
          d_kerr[l] = e;
          if (e == 2'd1 || e == 2'd2) begin
            e_cs[l + 1] = 1'b1;
            for (int c = l + 1; c < N; c++) e_cerr[c] = e;
            l = run_stage(2, l + 1, tmo);
            rep = l + 1;
            if (!tmo) begin
              f = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : e;
              d_cfound[l] = f;
              if (f == e) begin
                e_xs[l + 1] = 1'b1;
                l = run_stage(3, l + 1, tmo);
                rep = l + 1;
                if (!tmo) begin
                  ok = 1'b1;
                  nerr = e;
                end
              end
            end
          end
        end
      end
    end
    e_rv[rep]   = 1'b1;
    e_ok[rep]   = ok;
    e_nerr[rep] = nerr;
    e_tmo[rep]  = tmo;
    for (int c = s; c <= rep; c++) e_busy[c] = 1'b1;
    s_cur = s;
    r_cur = rep;
    n_blocks++;
  endfunction

  // Place requests in time order and derive block start cycles from them.
  function automatic void build_plan();
    int r;
    for (int c = 0; c < N; c++) begin
      d_szero[c]  = ($urandom_range(0, 1) == 1);
      d_kerr[c]   = 2'($urandom_range(0, 3));
      d_cfound[c] = 2'($urandom_range(0, 3));
    end
    r = 2;
    while (r < GEN_END) begin
      if (waiting >= 0 && r >= r_cur + 1) begin
        sched_block(r_cur + 2);
        waiting = -1;
      end
      d_req[r] = 1'b1;
      if (r >= s_cur && r <= r_cur) begin
        if (waiting >= 0) begin
          for (int c = r + 1; c < N; c++) e_ovf[c] = 1'b1;
        end else begin
          waiting = r;
        end
      end else if (r < s_cur) begin
        waiting = r;
      end else begin
        sched_block(r + 1);
      end
      r += ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 60);
    end
    if (waiting >= 0) sched_block(r_cur + 2);
    // Stray done pulses outside their own stage must be ignored.
    for (int c = 0; c < N; c++)
      for (int id = 0; id < 4; id++)
        if (!win[id][c] && $urandom_range(0, 15) == 0) d_done[id][c] = 1'b1;
  endfunction

  // Per-cycle comparison of every output against the planned timeline
  always @(negedge clk) begin
    if (run) begin
      chk("synd_start",    int'(synd_start),    int'(e_ss[cyc]));
      chk("kes_start",     int'(kes_start),     int'(e_ks[cyc]));
      chk("chien_start",   int'(chien_start),   int'(e_cs[cyc]));
      chk("corr_start",    int'(corr_start),    int'(e_xs[cyc]));
      chk("chien_err_num", int'(chien_err_num), int'(e_cerr[cyc]));
      chk("res_valid",     int'(res_valid),     int'(e_rv[cyc]));
      chk("res_ok",        int'(res_ok),        int'(e_ok[cyc]));
      chk("res_nerr",      int'(res_nerr),      int'(e_nerr[cyc]));
      chk("res_tmo",       int'(res_tmo),       int'(e_tmo[cyc]));
      chk("busy",          int'(busy),          int'(e_busy[cyc]));
      chk("buf_rd_sel",    int'(buf_rd_sel),    int'(e_rd[cyc]));
      chk("buf_wr_sel",    int'(buf_wr_sel),    int'(e_wr[cyc]));
      chk("blk_ovf",       int'(blk_ovf),       int'(e_ovf[cyc]));
    end
  end

  task automatic zero_inputs();
    blk_req = 1'b0; synd_done = 1'b0; synd_zero = 1'b0;
    kes_done = 1'b0; kes_err_num = 2'd0; chien_done = 1'b0;
    chien_found = 2'd0; corr_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       int'(busy),          0);
    chk({tag, "_blk_ovf"},    int'(blk_ovf),       0);
    chk({tag, "_buf_wr"},     int'(buf_wr_sel),    0);
    chk({tag, "_buf_rd"},     int'(buf_rd_sel),    0);
    chk({tag, "_chien_err"},  int'(chien_err_num), 0);
    chk({tag, "_chien_st"},   int'(chien_start),   0);
    chk({tag, "_res_valid"},  int'(res_valid),     0);
  endtask

  initial begin
    build_plan();
    #2;
    chk_all_zero("reset");
    #10 rst = 1'b0;

    // Planned random phase
    for (int c = 0; c < N; c++) begin
      @(posedge clk); #1;
      cyc         = c;
      run         = 1'b1;
      blk_req     = d_req[c];
      synd_done   = d_done[0][c];
      kes_done    = d_done[1][c];
      chien_done  = d_done[2][c];
      corr_done   = d_done[3][c];
      synd_zero   = d_szero[c];
      kes_err_num = d_kerr[c];
      chien_found = d_cfound[c];
    end
    #6 run = 1'b0;
    cyc = -1;

    // Directed: block into CHIEN, then asynchronous reset mid-stage
    @(posedge clk); #1; zero_inputs(); blk_req = 1'b1;
    @(posedge clk); #1; blk_req = 1'b0; #4 chk("dir_synd_start", int'(synd_start), 1);
    @(posedge clk); #1;
    @(posedge clk); #1; synd_done = 1'b1; synd_zero = 1'b0;
    @(posedge clk); #1; synd_done = 1'b0; #4 chk("dir_kes_start", int'(kes_start), 1);
    @(posedge clk); #1; kes_done = 1'b1; kes_err_num = 2'd2;
    @(posedge clk); #1; kes_done = 1'b0; kes_err_num = 2'd0;
    #4 chk("dir_chien_start", int'(chien_start), 1);
    chk("dir_chien_err", int'(chien_err_num), 2);
    @(posedge clk); #3; rst = 1'b1; #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1; chien_done = 1'b1; chien_found = 2'd2;
    @(posedge clk); #1; chien_done = 1'b0; chien_found = 2'd0; #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #5 chk("post_rst_res_valid", int'(res_valid), 0);
    end

    // Directed: clean block after reset restarts from buffer 0
    @(posedge clk); #1; blk_req = 1'b1;
    @(posedge clk); #1; blk_req = 1'b0;
    #4 chk("clean_synd_start", int'(synd_start), 1);
    chk("clean_buf_rd", int'(buf_rd_sel), 0);
    chk("clean_buf_wr", int'(buf_wr_sel), 1);
    chk("clean_busy", int'(busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1; synd_done = 1'b1; synd_zero = 1'b1;
    @(posedge clk); #1; synd_done = 1'b0; synd_zero = 1'b0;
    #4 chk("clean_res_valid", int'(res_valid), 1);
    chk("clean_res_ok", int'(res_ok), 1);
    chk("clean_res_nerr", int'(res_nerr), 0);
    chk("clean_res_tmo", int'(res_tmo), 0);
    chk("clean_kes_start", int'(kes_start), 0);
    @(posedge clk); #5 chk("clean_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rs_dec_ctrl.md
Name: rs_dec_ctrl

Overview:
- Sequences one RS(255,251) codeword through the decoder stages: syndrome → key-equation solver → Chien search → error correction → result report.
- Sits between the byte-input framer and the stage datapaths. Drives every stage's start pulse and consumes each stage's done pulse.
- Owns the ping-pong codeword buffer select and a per-stage watchdog.
- Accepts the next block's start while busy (one-deep pending queue).

Parameters:
- WDOG_CYC, 512, max cycles allowed in any one stage before abort (≥ 260).
- WDOG_W, 10, watchdog counter width; must hold WDOG_CYC.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- blk_req  in  1  pulse: a full 255-byte codeword is in buffer buf_wr_sel
- blk_ovf  out  1  sticky: blk_req arrived while pending already set; cleared by rst only
- buf_wr_sel  out  1  buffer the framer writes next
- buf_rd_sel  out  1  buffer the stages read for the active block
- synd_start  out  1  pulse
- synd_done  in  1  pulse
- synd_zero  in  1  all four syndromes zero; valid with synd_done
- kes_start  out  1  pulse
- kes_done  in  1  pulse
- kes_err_num  in  2  error-locator degree 0..2; 3 = uncorrectable; valid with kes_done
- chien_start  out  1  pulse
- chien_err_num  out  2  registered kes_err_num, held stable through CHIEN
- chien_done  in  1  pulse
- chien_found  in  2  roots found; valid with chien_done
- corr_start  out  1  pulse
- corr_done  in  1  pulse
- busy  out  1  state != IDLE
- res_valid  out  1  one-cycle result pulse
- res_ok  out  1  block clean or corrected; valid with res_valid
- res_nerr  out  2  errors corrected; valid with res_valid
- res_tmo  out  1  watchdog abort; valid with res_valid

Behaviour:
- Reset values: all outputs 0; state IDLE; pending 0; buf_wr_sel 0, buf_rd_sel 0.
- States and transitions:
  - IDLE: if pending or blk_req → SYND. Assert synd_start on the entry cycle. buf_rd_sel <= current buf_wr_sel. buf_wr_sel toggles.
  - SYND: on synd_done:
    - synd_zero=1 → REPORT (ok=1, nerr=0).
    - else → KES, kes_start pulse.
  - KES: on kes_done:
    - kes_err_num=0 or 3 → REPORT (ok=0).
    - else latch err_num → CHIEN, chien_start pulse.
  - CHIEN: on chien_done:
    - chien_found==err_num → CORR, corr_start pulse.
    - else → REPORT (ok=0).
  - CORR: on corr_done → REPORT (ok=1, nerr=err_num).
  - REPORT: res_valid=1 for exactly one cycle, then IDLE.
- All start outputs are single-cycle pulses, registered, asserted the cycle after the transition decision. Minimum latency from blk_req to synd_start is 1 cycle.
- Stage done pulses are ignored in any state other than the matching one; no state change results.
- Done pulse on the same cycle as the start pulse: not accepted. The earliest accepted done is the cycle after start.
- Watchdog:
  - Clears on every stage entry and increments each cycle in SYND/KES/CHIEN/CORR.
  - At count == WDOG_CYC-1 without the done pulse → REPORT with res_tmo=1, ok=0.
  - A done pulse arriving on the expiry cycle wins; no timeout.
- Pending queue:
  - blk_req while busy sets pending (no buffer toggle yet). Toggle happens when pending is consumed in IDLE.
  - blk_req while pending=1 sets blk_ovf; the request is dropped.
  - blk_req on the same cycle REPORT→IDLE is captured as pending. IDLE then starts it next cycle.
- rst mid-operation: returns to IDLE immediately and discards pending. No res_valid is emitted for the aborted block.

Optional Feature:
- RS_DEC_STATS_EN
- When defined, add ports stat_clr (in, 1) and three 16-bit outputs: stat_blk, stat_corr, stat_fail.
  - Counters increment on res_valid: total blocks; res_ok with nerr>0; !res_ok.
  - Counters saturate at 16'hFFFF.
  - Sync clear on stat_clr. stat_clr wins over a same-cycle increment.
- When undefined, no ports and no counters exist.

Decomposition:
- Shared package rs_pkg:
  - state enum (IDLE, SYND, KES, CHIEN, CORR, REPORT)
  - RS_N=255, RS_K=251, RS_T=2
  - ERR_UNCORR=2'd3
- One sub-module: rs_dec_wdog (loadable watchdog counter with expire output).
- The FSM itself stays flat.

Test Plan:
- blk_req; synd_done with synd_zero=1 two cycles later → res_valid, ok=1, nerr=0; no kes_start ever.
- Full path: kes_err_num=2, chien_found=2, corr_done → chien_err_num=2 through CHIEN; res ok=1 nerr=2; buf_rd_sel=0, then 1 on the next block.
- kes_err_num=2, chien_found=1 → res ok=0, tmo=0; corr_start never asserted.
- No synd_done for 512 cycles → res_tmo=1 on cycle 512 after synd_start; next pending block then starts normally.
- Three blk_req pulses while in KES → pending=1, blk_ovf=1. Exactly two blocks are reported; buffer selects alternate.
- rst asserted in CHIEN → all outputs 0 asynchronously; no res_valid. A later blk_req restarts from buf_wr_sel=0.
